instr_realign: RTL and testbench

- Frontend stage between the I$ fetch data path and the instruction queue; the producer side of the queue's instr/addr/valid input.
- Splits each fetch block into up to INSTR_PER_FETCH instructions. These may be 16-bit compressed or 32-bit.
- Emits one instruction per halfword-slot with its address and a valid mask.
- Stitches 32-bit instructions that straddle two consecutive fetch blocks by carrying the upper-straddling halfword across cycles.

---
 rtl/instr_realign_pkg.sv | 13 +
 rtl/instr_realign.sv | 145 ++++++++++++++
 tb/tb_instr_realign.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_realign_pkg.sv
// Shared fetch-path constants and the compressed-instruction test, also used
// by the instruction queue.
package instr_realign_pkg;

   localparam int FETCH_WIDTH     = 64;
   localparam int INSTR_PER_FETCH = FETCH_WIDTH / 16;

   // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
   function automatic logic is_rvc(input logic [15:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/instr_realign.sv
// instr_realign: splits a fetch block into per-halfword instruction slots.
// Build option INSTR_REALIGN_RVC_EN: when defined, 16-bit compressed
// instructions are decoded and 32-bit instructions straddling two fetch
// blocks are stitched via a carried halfword. When undefined, every
// instruction is a word-aligned 32-bit instruction and no state is kept.
module instr_realign #(
   parameter int FETCH_WIDTH     = instr_realign_pkg::FETCH_WIDTH,
   parameter int INSTR_PER_FETCH = FETCH_WIDTH / 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   input  logic                              valid_i,
   input  logic                              ex_i,
   input  logic [63:0]                       address_i,
   input  logic [FETCH_WIDTH-1:0]            data_i,
   input  logic                              ready_i,
   output logic [INSTR_PER_FETCH-1:0][31:0]  instr_o,
   output logic [INSTR_PER_FETCH-1:0][63:0]  addr_o,
   output logic [INSTR_PER_FETCH-1:0]        valid_o,
   output logic                              serving_unaligned_o
);
   import instr_realign_pkg::*;

   localparam int LB = $clog2(FETCH_WIDTH / 8);  // byte-offset bits in a block
   localparam int SW = LB - 1;                   // halfword slot index width

   // One spare zero halfword on top so hwx[i+1] is always in range.
   logic [INSTR_PER_FETCH:0][15:0]   hwx;
   logic [INSTR_PER_FETCH-1:0][63:0] slot_addr;
   logic [SW-1:0]                    s;

   assign hwx = {16'h0, data_i};
   assign s   = address_i[LB-1:1];

   for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_slot_addr
      assign slot_addr[g] = {address_i[63:LB], SW'(g), 1'b0};
   end

`ifdef INSTR_REALIGN_RVC_EN
   logic        unaligned_q, unaligned_d;
   logic [15:0] saved_hw_q, saved_hw_d;
   logic [63:0] saved_addr_q, saved_addr_d;
   logic        stitch, straddle, skip;
   logic [15:0] str_hw;
   logic [63:0] str_addr;

   // Scan the block left to right, emitting one instruction per start halfword.
   always_comb begin
      instr_o             = '0;
      addr_o              = slot_addr;
      valid_o             = '0;
      serving_unaligned_o = 1'b0;
      straddle            = 1'b0;
      skip                = 1'b0;
      str_hw              = '0;
      str_addr            = '0;
      // A carry only continues into the block that directly follows it;
      // anything else is a redirect and the carried halfword is dropped.
      stitch = unaligned_q && (s == '0) && (address_i == saved_addr_q + 64'd2);
      if (valid_i && ex_i) begin
         valid_o[s] = 1'b1;
      end else if (valid_i) begin
         if (stitch) begin
            instr_o[0]          = {hwx[0], saved_hw_q};
            addr_o[0]           = saved_addr_q;
            valid_o[0]          = 1'b1;
            serving_unaligned_o = 1'b1;
            skip                = 1'b1;
         end
         for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            if (skip) begin
               skip = 1'b0;
            end else if (i >= int'(s)) begin
               if (is_rvc(hwx[i])) begin
                  instr_o[i] = {16'h0, hwx[i]};
                  valid_o[i] = 1'b1;
               end else if (i < INSTR_PER_FETCH - 1) begin
                  instr_o[i] = {hwx[i+1], hwx[i]};
                  valid_o[i] = 1'b1;
                  skip       = 1'b1;
               end else begin
                  straddle = 1'b1;
                  str_hw   = hwx[i];
                  str_addr = slot_addr[i];
               end
            end
         end
      end
   end

   // Carry state moves only when the queue takes the block; flush wins.
   always_comb begin
      unaligned_d  = unaligned_q;
      saved_hw_d   = saved_hw_q;
      saved_addr_d = saved_addr_q;
      if (flush_i) begin
         unaligned_d = 1'b0;
      end else if (valid_i && ready_i) begin
         unaligned_d = straddle;
         if (straddle) begin
            saved_hw_d   = str_hw;
            saved_addr_d = str_addr;
         end
      end
   end

   // Carry registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         unaligned_q  <= 1'b0;
         saved_hw_q   <= '0;
         saved_addr_q <= '0;
      end else begin
         unaligned_q  <= unaligned_d;
         saved_hw_q   <= saved_hw_d;
         saved_addr_q <= saved_addr_d;
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{clk_i, rst_i, flush_i, ready_i, address_i[0]};

   // Word-aligned only: every even halfword from s starts a 32-bit instruction.
   always_comb begin
      instr_o             = '0;
      addr_o              = slot_addr;
      valid_o             = '0;
      serving_unaligned_o = 1'b0;
      if (valid_i && !address_i[1]) begin
         if (ex_i) begin
            valid_o[s] = 1'b1;
         end else begin
            for (int i = 0; i < INSTR_PER_FETCH; i += 2) begin
               if (i >= int'(s)) begin
                  instr_o[i] = {hwx[i+1], hwx[i]};
                  valid_o[i] = 1'b1;
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_realign.sv
module tb_instr_realign;
   import instr_realign_pkg::*;

   localparam int FW = FETCH_WIDTH;
   localparam int N  = INSTR_PER_FETCH;
`ifdef INSTR_REALIGN_RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_i, flush_i, valid_i, ex_i, ready_i;
   logic [63:0]        address_i;
   logic [FW-1:0]      data_i;
   logic [N-1:0][31:0] instr_o;
   logic [N-1:0][63:0] addr_o;
   logic [N-1:0]       valid_o;
   logic               serving_unaligned_o;

   instr_realign dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
      .ex_i(ex_i), .address_i(address_i), .data_i(data_i), .ready_i(ready_i),
      .instr_o(instr_o), .addr_o(addr_o), .valid_o(valid_o),
      .serving_unaligned_o(serving_unaligned_o)
   );

   int tests = 0;
   int fails = 0;

   // reference model state: the halfword waiting for its upper half
   bit          m_carry = 1'b0;
   logic [15:0] m_hw    = '0;
   logic [63:0] m_addr  = '0;
   bit          p_str;
   logic [15:0] p_hw;
   logic [63:0] p_addr;
   logic [N-1:0][31:0] e_instr;
   logic [N-1:0][63:0] e_addr;
   logic [N-1:0]       e_valid;
   bit                 e_serv;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected outputs from the current inputs and the modelled carry.
   task automatic model();
      logic [15:0] h [N];
      int p, s;
      for (int i = 0; i < N; i++) h[i] = data_i[16*i +: 16];
      e_instr = '0; e_valid = '0; e_serv = 1'b0; p_str = 1'b0;
      for (int i = 0; i < N; i++) e_addr[i] = (address_i & ~64'(FW/8 - 1)) + 64'(2*i);
      s = int'((address_i % 64'(FW/8)) / 2);
      if (!valid_i) return;
`ifdef INSTR_REALIGN_RVC_EN
      if (ex_i) begin e_valid[s] = 1'b1; return; end
      p = s;
      if (m_carry && s == 0 && address_i == m_addr + 64'd2) begin
         e_instr[0] = {h[0], m_hw}; e_addr[0] = m_addr; e_valid[0] = 1'b1; e_serv = 1'b1; p = 1;
      end
      while (p < N) begin
         if (h[p][1:0] != 2'b11) begin
            e_instr[p] = {16'h0, h[p]}; e_valid[p] = 1'b1; p += 1;
         end else if (p == N - 1) begin
            p_str = 1'b1; p_hw = h[p]; p_addr = e_addr[p]; p += 1;
         end else begin
            e_instr[p] = {h[p+1], h[p]}; e_valid[p] = 1'b1; p += 2;
         end
      end
`else
      if (address_i[1]) return;
      if (ex_i) begin e_valid[s] = 1'b1; return; end
      for (int k = s; k < N; k += 2) begin
         e_instr[k] = {h[k+1], h[k]}; e_valid[k] = 1'b1;
      end
`endif
   endtask

   task automatic apply(input bit r, input bit f, input bit v, input bit e,
                        input logic [63:0] a, input logic [FW-1:0] d, input bit rd);
      rst_i = r; flush_i = f; valid_i = v; ex_i = e; address_i = a; data_i = d; ready_i = rd;
      #2;
      model();
      if (!flush_i) begin
         chk("valid_o", valid_o, e_valid);
         chk("serving_unaligned_o", serving_unaligned_o, e_serv);
         chk("addr_o", addr_o, e_addr);
         if (valid_i) chk("instr_o", instr_o, e_instr);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_i) m_carry = 1'b0;
      else if (flush_i) m_carry = 1'b0;
      else if (valid_i && ready_i) begin
         m_carry = p_str;
         if (p_str) begin m_hw = p_hw; m_addr = p_addr; end
      end
      #1;
   endtask

   localparam logic [63:0] DA = 64'h0008_0004_0002_0001;
   localparam logic [63:0] DB = 64'h0297_4501_0000_0013;
   localparam logic [63:0] DC = 64'h0001_0001_0001_0000;
   localparam logic [63:0] DR = 64'h0001_0001_0001_0001;

   initial begin
      logic [63:0]   pc;
      logic [FW-1:0] d;
      logic [15:0]   hw;
      bit            v, e, hold;
      @(posedge clk); #1;
      // reset state
      apply(1, 0, 0, 0, 64'h0, '0, 0);
      chk("rst_valid", valid_o, '0); chk("rst_serving", serving_unaligned_o, 1'b0);
      tick();
      apply(0, 0, 0, 0, 64'h1000, DA, 1);
      chk("idle_valid", valid_o, '0);
      tick();
      // plain block
      apply(0, 0, 1, 0, 64'h1000, DA, 1);
      chk("t1_valid", valid_o, RVC ? 4'b1111 : 4'b0101);
      chk("t1_instr", instr_o, RVC ? 128'h00000008_00000004_00000002_00000001
                                   : 128'h00000000_00080004_00000000_00020001);
      chk("t1_addr", addr_o, {64'h1006, 64'h1004, 64'h1002, 64'h1000});
      tick();
      // trailing straddle, then stitched slot while the queue stalls
      apply(0, 0, 1, 0, 64'h1000, DB, 1);
      chk("t2_valid", valid_o, 4'b0101);
      chk("t2_instr", instr_o, RVC ? 128'h00000000_00004501_00000000_00000013
                                   : 128'h00000000_02974501_00000000_00000013);
      tick();
      for (int k = 0; k < 4; k++) begin
         apply(0, 0, 1, 0, 64'h1008, DC, k == 3);
         chk("t3_serving", serving_unaligned_o, RVC);
         chk("t3_valid", valid_o, RVC ? 4'b1111 : 4'b0101);
         if (RVC) chk("t3_addr", addr_o, {64'h100e, 64'h100c, 64'h100a, 64'h1006});
         if (RVC) chk("t3_instr", instr_o, 128'h00000001_00000001_00000001_00000297);
         tick();
      end
      apply(0, 0, 1, 0, 64'h1008, DC, 1);
      chk("t3_cleared", serving_unaligned_o, 1'b0);
      tick();
      // flush drops the carry
      apply(0, 0, 1, 0, 64'h1000, DB, 1); tick();
      apply(0, 1, 0, 0, 64'h0, '0, 1);    tick();
      apply(0, 0, 1, 0, 64'h2000, DC, 1);
      chk("t4_serving", serving_unaligned_o, 1'b0);
      chk("t4_valid", valid_o, RVC ? 4'b1111 : 4'b0101);
      tick();
      // start halfword 2, with and without fault
      apply(0, 0, 1, 0, 64'h1004, DR, 1);
      chk("t5_valid", valid_o, RVC ? 4'b1100 : 4'b0100);
      tick();
      apply(0, 0, 1, 1, 64'h1004, DR, 1);
      chk("t5_ex_valid", valid_o, 4'b0100);
      chk("t5_ex_instr", instr_o, 128'h0);
      tick();
      // reset mid-carry
      apply(0, 0, 1, 0, 64'h1000, DB, 1); tick();
      apply(1, 0, 0, 0, 64'h0, '0, 0);    tick();
      apply(0, 0, 0, 0, 64'h1008, DC, 1);
      chk("t6_idle_valid", valid_o, '0);
      tick();
      apply(0, 0, 1, 0, 64'h1008, DC, 1);
      chk("t6_serving", serving_unaligned_o, 1'b0);
      tick();

      // randomized traffic, mostly sequential so straddles get stitched
      pc = 64'h8000; d = '0; v = 1'b0; e = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         hold = valid_i && !ready_i && !flush_i && !rst_i && ($urandom_range(3) != 0);
         if (!hold) begin
            case ($urandom_range(9))
               0:       pc = {$urandom, $urandom};
               1:       pc = (pc & ~64'(FW/8 - 1)) + 64'(FW/8) + 64'(2 * $urandom_range(N - 1));
               default: pc = (pc & ~64'(FW/8 - 1)) + 64'(FW/8);
            endcase
            pc[0] = 1'b0;
            for (int k = 0; k < N; k++) begin
               hw = 16'($urandom);
               if ($urandom_range(1) == 1) hw[1:0] = 2'b11;
               d[16*k +: 16] = hw;
            end
            v = ($urandom_range(9) != 0);
            e = ($urandom_range(19) == 0);
         end
         apply($urandom_range(199) == 0, $urandom_range(39) == 0, v, e, pc, d,
               $urandom_range(3) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
